// File: rtl/hls_mem_pkg.sv
// Shared definitions for HLS memory responders: preload FSM states and legal read latencies.
package hls_mem_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } ld_state_e;

  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

endpackage

// File: rtl/hls_mem_loader.sv
// Streamed preload engine: accepts a base/count request, then writes one word per accepted beat.
//
// state   | meaning
// LD_IDLE | waiting for load_start; kernel owns the write port
// LD_LOAD | accepting beats; preload owns the write port
// LD_DONE | one-cycle completion pulse, then back to LD_IDLE
module hls_mem_loader
  import hls_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [AW-1:0]    load_base,
  input  logic [AW:0]      load_count,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             load_busy,
  output logic             load_done,
  output logic             ld_we,
  output logic [AW-1:0]    ld_addr,
  output logic [WIDTH-1:0] ld_data,
  output logic             owns_port
);

  ld_state_e     state;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic [AW:0]   count_clamped;
  logic [AW-1:0] next_ptr;
  logic          beat;

  assign count_clamped = (load_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : load_count;
  // Wrap explicitly so non-power-of-two depths stay inside the array.
  assign next_ptr      = (ptr == AW'(DEPTH-1)) ? '0 : ptr + AW'(1);
  assign beat          = load_valid & load_ready;

  assign ld_we     = beat;
  assign ld_addr   = ptr;
  assign ld_data   = load_data;
  assign owns_port = (state == LD_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LD_IDLE;
      ptr        <= '0;
      remaining  <= '0;
      load_ready <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (load_start) begin
            ptr <= load_base;
            if (count_clamped == '0) begin
              state     <= LD_DONE;
              load_done <= 1'b1;
            end else begin
              remaining  <= count_clamped;
              state      <= LD_LOAD;
              load_ready <= 1'b1;
              load_busy  <= 1'b1;
            end
          end
        end
        LD_LOAD: begin
          if (beat) begin
            ptr       <= next_ptr;
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) begin
              state      <= LD_DONE;
              load_ready <= 1'b0;
              load_busy  <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        LD_DONE: begin
          state     <= LD_IDLE;
          load_done <= 1'b0;
        end
        default: begin
          state      <= LD_IDLE;
          load_ready <= 1'b0;
          load_busy  <= 1'b0;
          load_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hls_mem_responder.sv
// Memory-side responder for HLS kernel memory ports: 2 read ports, 1 write port, debug read
// and a streamed preload engine that takes over the write port while loading.
module hls_mem_responder
  import hls_mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int RD_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wen,
  input  logic [AW-1:0]    debug_addr,
  output logic [WIDTH-1:0] debug_data,
  input  logic             load_start,
  input  logic [AW-1:0]    load_base,
  input  logic [AW:0]      load_count,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             load_busy,
  output logic             load_done,
  output logic             drop_err
);

  if (!(RD_LAT == RD_LAT_COMB || RD_LAT == RD_LAT_REG) || DEPTH > 2**AW) begin : g_bad_cfg
    $error("hls_mem_responder: illegal RD_LAT or DEPTH exceeds address space");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             ld_we;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             owns_port;

  hls_mem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_count (load_count),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .owns_port  (owns_port)
  );

  // Array has no reset so preloaded contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else if (wen && !owns_port) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err <= 1'b0;
    end else if (wen && owns_port) begin
      drop_err <= 1'b1;
    end
  end

  assign debug_data = mem[debug_addr];

  if (RD_LAT == RD_LAT_REG) begin : g_rd_reg
    logic [WIDTH-1:0] rdata0_q;
    logic [WIDTH-1:0] rdata1_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata0_q <= '0;
        rdata1_q <= '0;
      end else begin
        rdata0_q <= mem[raddr0];
        rdata1_q <= mem[raddr1];
      end
    end
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
  end else begin : g_rd_comb
    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
  end

endmodule

// File: tb/tb_hls_mem_responder.sv
// Bench for hls_mem_responder: one combinational-read and one registered-read instance share stimulus
// and are compared every cycle against a shadow-memory model of the preload/write rules.
module tb_hls_mem_responder;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] raddr0, raddr1, waddr, debug_addr, load_base;
  logic [W-1:0]  wdata, load_data;
  logic          wen, load_start, load_valid;
  logic [AW:0]   load_count;

  logic [W-1:0] rdata0_c, rdata1_c, debug_c, rdata0_r, rdata1_r, debug_r;
  logic ready_c, busy_c, done_c, drop_c, ready_r, busy_r, done_r, drop_r;

  hls_mem_responder #(.WIDTH(W), .DEPTH(D), .AW(AW), .RD_LAT(0)) u_comb (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rdata0_c), .raddr1(raddr1), .rdata1(rdata1_c),
    .waddr(waddr), .wdata(wdata), .wen(wen), .debug_addr(debug_addr), .debug_data(debug_c),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data), .load_ready(ready_c), .load_busy(busy_c),
    .load_done(done_c), .drop_err(drop_c));

  hls_mem_responder #(.WIDTH(W), .DEPTH(D), .AW(AW), .RD_LAT(1)) u_reg (
    .clk(clk), .rst(rst), .raddr0(raddr0), .rdata0(rdata0_r), .raddr1(raddr1), .rdata1(rdata1_r),
    .waddr(waddr), .wdata(wdata), .wen(wen), .debug_addr(debug_addr), .debug_data(debug_r),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data), .load_ready(ready_r), .load_busy(busy_r),
    .load_done(done_r), .drop_err(drop_r));

  int vecs = 0;
  int errs = 0;

  // Behavioural model: shadow memory plus "words still to load" bookkeeping.
  logic [W-1:0] m [D];
  bit           kn [D];
  bit           m_busy, m_done, m_drop;
  int           m_left, m_ptr;
  logic [W-1:0] e_r0, e_r1;
  bit           e_k0, e_k1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    raddr0 = '0; raddr1 = '0; waddr = '0; debug_addr = '0; load_base = '0;
    wdata = '0; load_data = '0; wen = 0; load_start = 0; load_valid = 0; load_count = '0;
  endtask

  // Called at a negedge with inputs already set; returns at the following negedge.
  task automatic cyc();
    #1;
    if (kn[debug_addr]) begin
      chk("debug_comb", debug_c, m[debug_addr]);
      chk("debug_reg", debug_r, m[debug_addr]);
    end
    if (kn[raddr0]) chk("rdata0_comb", rdata0_c, m[raddr0]);
    if (kn[raddr1]) chk("rdata1_comb", rdata1_c, m[raddr1]);
    chk("status_comb", 32'({ready_c, busy_c, done_c, drop_c}), 32'({m_busy, m_busy, m_done, m_drop}));
    chk("status_reg", 32'({ready_r, busy_r, done_r, drop_r}), 32'({m_busy, m_busy, m_done, m_drop}));
    e_r0 = m[raddr0]; e_k0 = kn[raddr0];
    e_r1 = m[raddr1]; e_k1 = kn[raddr1];
    if (m_busy) begin
      if (wen) m_drop = 1;
      if (load_valid) begin
        m[m_ptr] = load_data; kn[m_ptr] = 1;
        m_ptr = (m_ptr + 1) % D;
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end
    end else begin
      if (wen) begin m[waddr] = wdata; kn[waddr] = 1; end
      if (m_done) m_done = 0;
      else if (load_start) begin
        m_ptr  = int'(load_base);
        m_left = (int'(load_count) > D) ? D : int'(load_count);
        if (m_left == 0) m_done = 1; else m_busy = 1;
      end
    end
    @(posedge clk); #1;
    if (e_k0) chk("rdata0_reg", rdata0_r, e_r0);
    if (e_k1) chk("rdata1_reg", rdata1_r, e_r1);
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset asynchronously and releases it two cycles later.
  task automatic do_reset();
    rst = 0;
    idle_inputs();
    #1;
    chk("rst_status_comb", 32'({ready_c, busy_c, done_c, drop_c}), 32'd0);
    chk("rst_status_reg", 32'({ready_r, busy_r, done_r, drop_r}), 32'd0);
    chk("rst_rdata0_reg", rdata0_r, 32'd0);
    m_busy = 0; m_done = 0; m_drop = 0;
    e_r0 = '0; e_r1 = '0; e_k0 = 1; e_k1 = 1;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [7:0] gap_pat;
    logic [W-1:0] gap_dat [3];
    for (int i = 0; i < D; i++) begin m[i] = '0; kn[i] = 0; end
    m_left = 0; m_ptr = 0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Fill the whole array; count 40 clamps to 32.
    load_start = 1; load_base = 5'd7; load_count = 6'd40;
    cyc();
    load_start = 0; load_valid = 1;
    for (int i = 0; i < 32; i++) begin load_data = $urandom; cyc(); end
    load_valid = 0;
    chk("clamp_done", 32'(done_c), 32'd1);
    cyc();

    // base 10, count 2, beats {10,5}
    load_start = 1; load_base = 5'd10; load_count = 6'd2;
    cyc();
    load_start = 0;
    chk("pre2_ready", 32'(ready_c), 32'd1);
    load_valid = 1; load_data = 32'd10; cyc();
    load_data = 32'd5; cyc();
    load_valid = 0;
    chk("pre2_done", 32'(done_c), 32'd1);
    chk("pre2_ready_off", 32'(ready_c), 32'd0);
    cyc();
    chk("pre2_done_pulse", 32'(done_c), 32'd0);
    debug_addr = 5'd10; #1; chk("pre2_mem10", debug_c, 32'd10);
    debug_addr = 5'd11; #1; chk("pre2_mem11", debug_c, 32'd5);

    // kernel write in IDLE
    wen = 1; waddr = 5'd0; wdata = 32'd17;
    cyc();
    wen = 0; debug_addr = 5'd0; raddr0 = 5'd0; #1;
    chk("kw_debug0", debug_c, 32'd17);
    chk("kw_rdata0", rdata0_c, 32'd17);

    // same-edge read/write, registered read returns old then new
    wen = 1; waddr = 5'd3; wdata = 32'd8; raddr0 = 5'd0;
    cyc();
    wdata = 32'd9; raddr0 = 5'd3;
    cyc();
    wen = 0;
    chk("rfw_old", rdata0_r, 32'd8);
    cyc();
    chk("rfw_new", rdata0_r, 32'd9);

    // base 31, count 3, gapped valid -> wraps to 0,1
    gap_dat[0] = 32'd1; gap_dat[1] = 32'd2; gap_dat[2] = 32'd3;
    gap_pat = 8'b1001_0100;
    ndone = 0;
    load_start = 1; load_base = 5'd31; load_count = 6'd3;
    cyc();
    load_start = 0;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 8; i++) begin
        load_valid = gap_pat[i];
        load_data = gap_pat[i] ? gap_dat[k] : 32'hFFFF_FFFF;
        if (gap_pat[i]) k++;
        cyc();
        if (done_c) ndone++;
      end
    end
    load_valid = 0;
    repeat (3) begin cyc(); if (done_c) ndone++; end
    chk("wrap_done_once", 32'(ndone), 32'd1);
    debug_addr = 5'd31; #1; chk("wrap_mem31", debug_c, 32'd1);
    debug_addr = 5'd0;  #1; chk("wrap_mem0", debug_c, 32'd2);
    debug_addr = 5'd1;  #1; chk("wrap_mem1", debug_c, 32'd3);

    // kernel write during LOAD is dropped
    wen = 1; waddr = 5'd5; wdata = 32'd55;
    cyc();
    wen = 0;
    load_start = 1; load_base = 5'd20; load_count = 6'd2;
    cyc();
    load_start = 0; wen = 1; waddr = 5'd5; wdata = 32'hDEAD;
    cyc();
    wen = 0;
    chk("drop_set", 32'(drop_c), 32'd1);
    load_valid = 1; load_data = 32'h20; cyc(); load_data = 32'h21; cyc();
    load_valid = 0;
    cyc(); cyc();
    debug_addr = 5'd5; #1; chk("drop_mem5", debug_c, 32'd55);
    chk("drop_sticky", 32'(drop_c), 32'd1);

    // reset after 1 of 4 beats
    load_start = 1; load_base = 5'd12; load_count = 6'd4;
    cyc();
    load_start = 0; load_valid = 1; load_data = 32'hAA;
    cyc();
    do_reset();
    debug_addr = 5'd12; #1; chk("rst_keep_mem12", debug_c, 32'hAA);
    chk("rst_drop_clr", 32'(drop_c), 32'd0);
    @(negedge clk);

    // count 0 -> done next cycle
    load_start = 1; load_base = 5'd3; load_count = 6'd0;
    cyc();
    load_start = 0;
    chk("cnt0_done", 32'(done_c), 32'd1);
    chk("cnt0_busy", 32'(busy_c), 32'd0);
    cyc();
    chk("cnt0_pulse", 32'(done_c), 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        @(negedge clk);
      end
      raddr0 = AW'($urandom); raddr1 = AW'($urandom); debug_addr = AW'($urandom);
      wen = ($urandom_range(0, 2) == 0); waddr = AW'($urandom); wdata = $urandom;
      load_start = ($urandom_range(0, 11) == 0);
      load_base = AW'($urandom); load_count = (AW+1)'($urandom_range(0, 40));
      load_valid = $urandom_range(0, 1) == 1; load_data = $urandom;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
